// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronizes the rx_top frame-done pulse and buffers each received byte
// with its error flag in a first-word-fall-through FIFO with occupancy and status.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_done_in,
   input  logic              rx_error_in,
   input  logic [7:0]        rx_data_in,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic              rd_err,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   input  logic              clr_overflow,
   output logic [7:0]        err_count
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   logic s1_q, s2_q, s3_q;
   logic [8:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] count_q, count_d;
   logic ovf_q, ovf_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic wr_stb, pop, wr_en;
   // rx_data_in/rx_error_in are stable while rx_done_in is high, so they are sampled raw
   assign wr_stb    = s2_q & ~s3_q;
   assign full      = count_q == FULL_CNT;
   assign empty     = count_q == '0;
   assign rd_valid  = ~empty;
   assign pop       = rd_valid & rd_ready;
   assign wr_en     = wr_stb & (~full | pop);
   assign {rd_err, rd_data} = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign err_count = err_cnt_q;
   always_comb begin
      wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = (wr_en & ~pop) ? count_q + 1'b1 : (~wr_en & pop) ? count_q - 1'b1 : count_q;
      ovf_d     = (wr_stb & full & ~pop) | (ovf_q & ~clr_overflow);
      err_cnt_d = (wr_en & rx_error_in & ~&err_cnt_q) ? err_cnt_q + 8'd1 : err_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         s1_q      <= rx_done_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         err_cnt_q <= err_cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_ptr_q] <= {rx_error_in, rx_data_in};
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table-driven checks of the synchronized FWFT receive FIFO.
module tb_uart_rx_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_done_in = 1'b0, rx_error_in = 1'b0, rd_ready = 1'b0, clr_overflow = 1'b0;
   logic [7:0] rx_data_in = 8'h00;
   logic       rd_valid, rd_err, full, empty, overflow;
   logic [7:0] rd_data, err_count;
   logic [4:0] count;
   int errors = 0, checks = 0;
   typedef struct {
      logic [7:0] data;
      logic       err;
      int         exp_count;
      logic       exp_full;
      logic       exp_ovf;
   } vec_t;
   vec_t burst[17];
   vec_t errv[3];
   int lat_exp[4];
   logic mon_en = 1'b0;
   logic [7:0] got[$];
   int max_cnt = 0;

   uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .rx_done_in(rx_done_in), .rx_error_in(rx_error_in),
      .rx_data_in(rx_data_in), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_err(rd_err), .count(count), .full(full), .empty(empty), .overflow(overflow),
      .clr_overflow(clr_overflow), .err_count(err_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_valid && rd_ready) got.push_back(rd_data);
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic e, input int hi);
      rx_data_in  = d;
      rx_error_in = e;
      rx_done_in  = 1'b1;
      repeat (hi) @(negedge clk);
      rx_done_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pop_chk(input string n, input logic [7:0] d, input logic e);
      chk({n, "_valid"}, int'(rd_valid), 1);
      chk({n, "_data"}, int'(rd_data), int'(d));
      chk({n, "_err"}, int'(rd_err), int'(e));
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) burst[i] = '{8'(i), 1'b0, i + 1, i == 15, 1'b0};
      burst[16] = '{8'hFF, 1'b0, 16, 1'b1, 1'b1};
      errv[0] = '{8'h11, 1'b1, 1, 1'b0, 1'b0};
      errv[1] = '{8'h22, 1'b0, 2, 1'b0, 1'b0};
      errv[2] = '{8'h33, 1'b1, 3, 1'b0, 1'b0};
      lat_exp = '{0, 0, 1, 1};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_valid", int'(rd_valid), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_errcnt", int'(err_count), 0);

      // single frame latency: valid after the third edge that sees rx_done_in high
      rx_data_in = 8'hA5; rx_error_in = 1'b0; rx_done_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("lat_valid_%0d", i), int'(rd_valid), lat_exp[i]);
      end
      rx_done_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("single_count", int'(count), 1);
      pop_chk("single", 8'hA5, 1'b0);
      chk("single_empty", int'(empty), 1);
      chk("single_count0", int'(count), 0);

      for (int i = 0; i < 17; i++) begin
         send(burst[i].data, burst[i].err, 2);
         chk($sformatf("burst_count_%0d", i), int'(count), burst[i].exp_count);
         chk($sformatf("burst_full_%0d", i), int'(full), int'(burst[i].exp_full));
         chk($sformatf("burst_ovf_%0d", i), int'(overflow), int'(burst[i].exp_ovf));
      end
      for (int i = 0; i < 16; i++) pop_chk($sformatf("drain_%0d", i), 8'(i), 1'b0);
      chk("drain_empty", int'(empty), 1);
      chk("drain_ovf_sticky", int'(overflow), 1);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      chk("clr_ovf", int'(overflow), 0);

      // full FIFO with pop coinciding with the write strobe
      for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0, 2);
      chk("fullpop_pre_full", int'(full), 1);
      rx_data_in = 8'h99; rx_error_in = 1'b0; rx_done_in = 1'b1;
      repeat (2) @(negedge clk);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0; rx_done_in = 1'b0;
      chk("fullpop_count", int'(count), 16);
      chk("fullpop_ovf", int'(overflow), 0);
      repeat (3) @(negedge clk);
      for (int i = 1; i < 16; i++) pop_chk($sformatf("fullpop_%0d", i), 8'h40 + 8'(i), 1'b0);
      pop_chk("fullpop_new", 8'h99, 1'b0);
      chk("fullpop_empty", int'(empty), 1);

      for (int i = 0; i < 3; i++) begin
         send(errv[i].data, errv[i].err, 2);
         chk($sformatf("errtag_count_%0d", i), int'(count), errv[i].exp_count);
      end
      for (int i = 0; i < 3; i++) pop_chk($sformatf("errtag_%0d", i), errv[i].data, errv[i].err);
      chk("errtag_errcnt", int'(err_count), 2);
      rd_ready = 1'b1;
      for (int i = 0; i < 260; i++) send(8'(i), 1'b1, 2);
      rd_ready = 1'b0;
      chk("errsat_errcnt", int'(err_count), 255);
      chk("errsat_empty", int'(empty), 1);

      send(8'h77, 1'b0, 50);
      repeat (5) @(negedge clk);
      chk("long_count", int'(count), 1);
      pop_chk("long", 8'h77, 1'b0);
      chk("long_empty", int'(empty), 1);

      rd_ready = 1'b1; mon_en = 1'b1;
      for (int i = 0; i < 40; i++) send(8'h80 + 8'(i), 1'b0, 2);
      repeat (2) @(negedge clk);
      mon_en = 1'b0; rd_ready = 1'b0;
      chk("wrap_size", got.size(), 40);
      for (int i = 0; i < 40 && i < got.size(); i++)
         chk($sformatf("wrap_%0d", i), int'(got[i]), 'h80 + i);
      chk("wrap_max_le_depth", int'(max_cnt <= 16), 1);

      // build a partially filled FIFO with overflow set, then reset mid-operation
      for (int i = 0; i < 17; i++) send(8'h60 + 8'(i), 1'b1, 2);
      rd_ready = 1'b1;
      repeat (11) @(negedge clk);
      rd_ready = 1'b0;
      chk("mid_pre_count", int'(count), 5);
      chk("mid_pre_ovf", int'(overflow), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_count", int'(count), 0);
      chk("mid_empty", int'(empty), 1);
      chk("mid_ovf", int'(overflow), 0);
      chk("mid_errcnt", int'(err_count), 0);
      chk("mid_valid", int'(rd_valid), 0);
      send(8'h5A, 1'b0, 2);
      chk("post_count", int'(count), 1);
      pop_chk("post", 8'h5A, 1'b0);
      chk("post_empty", int'(empty), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
